dcf77_frame_sequencer: RTL



---
 rtl/dcf77_pkg.sv | 36 +++
 rtl/dcf77_gap_timer.sv | 41 ++++
 rtl/dcf77_frame_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dcf77_pkg.sv
// Shared types and telegram bit positions for the DCF77 frame sequencer.
// Bit positions are absolute second numbers within the minute telegram.
package dcf77_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 59;

    // Start-of-time bit; everything below it (except bit 0) is not needed.
    localparam int TEL_LO  = 20;

    localparam int MIN_LO  = 21;
    localparam int MIN_HI  = 27;
    localparam int P1      = 28;
    localparam int HOUR_LO = 29;
    localparam int HOUR_HI = 34;
    localparam int P2      = 35;
    localparam int DAY_LO  = 36;
    localparam int DAY_HI  = 41;
    localparam int WDAY_LO = 42;
    localparam int WDAY_HI = 44;
    localparam int MON_LO  = 45;
    localparam int MON_HI  = 49;
    localparam int YEAR_LO = 50;
    localparam int YEAR_HI = 57;
    localparam int P3      = 58;

    function automatic logic digit_gt9(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/dcf77_gap_timer.sv
// Gap timer: counts 1 ms ticks since the last decoded second and flags the
// minute marker (missing second 59) and loss of signal.
module dcf77_gap_timer #(
    parameter int GAP_MS  = 1500,
    parameter int LOSS_MS = 2500,
    parameter int CNT_W   = 12
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic tick_in,
    input  logic flag_in,
    output logic marker_out,
    output logic loss_out
);

    localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'(GAP_MS - 1);
    localparam logic [CNT_W-1:0] LOSS_PRE = CNT_W'(LOSS_MS - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX = CNT_W'(LOSS_MS);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // A marker is only meaningful as a gap after at least one received
    // second, so a silent input after reset never looks like a minute edge.
    assign marker_out = tick_in && !flag_in && armed && (cnt == GAP_PRE);
    assign loss_out   = tick_in && !flag_in && (cnt == LOSS_PRE);

    // Flag clears the count (and wins over a coincident tick); ticks saturate at LOSS_MS.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (flag_in) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (tick_in && (cnt != LOSS_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dcf77_frame_sequencer.sv
// DCF77 frame sequencer: frames the decoded second stream on minute markers,
// checks start bits and parity, and publishes validated BCD time/date.
// Optional build macro DCF77_RANGE_CHECK_EN adds BCD digit and field range
// checks to frame acceptance.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SYNC    | no minute marker yet (or signal lost); flags ignored
// COLLECT | storing one bit per flag at position idx
// CHECK   | single cycle: judge the finished frame, restart at idx 0
module dcf77_frame_sequencer
    import dcf77_pkg::*;
#(
    parameter int GAP_MS  = 1500,
    parameter int LOSS_MS = 2500,
    parameter int CNT_W   = 12
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       tick_in,
    input  logic       bit_in,
    input  logic       flag_in,
    output logic [6:0] min_out,
    output logic [5:0] hour_out,
    output logic [5:0] day_out,
    output logic [2:0] wday_out,
    output logic [4:0] month_out,
    output logic [7:0] year_out,
    output logic       valid_out,
    output logic       synced_out,
    output logic       err_out
);

    state_t                       state;
    logic [5:0]                   idx;
    logic                         start_bit;
    logic [FRAME_BITS-1:TEL_LO]   tel;
    logic                         marker;
    logic                         loss;
    logic                         frame_ok;
    logic                         range_ok;

    logic [6:0] f_min;
    logic [5:0] f_hour;
    logic [5:0] f_day;
    logic [2:0] f_wday;
    logic [4:0] f_mon;
    logic [7:0] f_year;

    dcf77_gap_timer #(
        .GAP_MS  (GAP_MS),
        .LOSS_MS (LOSS_MS),
        .CNT_W   (CNT_W)
    ) u_gap_timer (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .tick_in    (tick_in),
        .flag_in    (flag_in),
        .marker_out (marker),
        .loss_out   (loss)
    );

    assign f_min  = tel[MIN_HI:MIN_LO];
    assign f_hour = tel[HOUR_HI:HOUR_LO];
    assign f_day  = tel[DAY_HI:DAY_LO];
    assign f_wday = tel[WDAY_HI:WDAY_LO];
    assign f_mon  = tel[MON_HI:MON_LO];
    assign f_year = tel[YEAR_HI:YEAR_LO];

`ifdef DCF77_RANGE_CHECK_EN
    // Reject non-decimal digits and calendar fields outside their legal range.
    always_comb begin
        range_ok = !( digit_gt9(f_min[3:0])  || (f_min[6:4] > 3'd5)
                   || digit_gt9(f_hour[3:0]) || (f_hour[5:4] == 2'd3)
                   || ((f_hour[5:4] == 2'd2) && (f_hour[3:0] > 4'd3))
                   || digit_gt9(f_day[3:0])  || (f_day == 6'h00)
                   || ((f_day[5:4] == 2'd3) && (f_day[3:0] > 4'd1))
                   || (f_wday == 3'd0)
                   || digit_gt9(f_mon[3:0])  || (f_mon == 5'h00)
                   || (f_mon[4] && (f_mon[3:0] > 4'd2))
                   || digit_gt9(f_year[3:0]) || digit_gt9(f_year[7:4]) );
    end
`else
    assign range_ok = 1'b1;
`endif

    // Frame is good with exactly 59 bits, correct start bits and even parity per block.
    assign frame_ok = (idx == 6'(FRAME_BITS)) && !start_bit && tel[TEL_LO]
                   && !(^tel[P1:MIN_LO]) && !(^tel[P2:HOUR_LO]) && !(^tel[P3:DAY_LO])
                   && range_ok;

    // Sequencing FSM with registered time outputs and status pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= SYNC;
            idx        <= '0;
            start_bit  <= 1'b0;
            tel        <= '0;
            min_out    <= '0;
            hour_out   <= '0;
            day_out    <= '0;
            wday_out   <= '0;
            month_out  <= '0;
            year_out   <= '0;
            valid_out  <= 1'b0;
            synced_out <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            case (state)
                SYNC: begin
                    if (marker) begin
                        state      <= COLLECT;
                        idx        <= '0;
                        synced_out <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (loss) begin
                        state      <= SYNC;
                        synced_out <= 1'b0;
                    end else if (marker) begin
                        state <= CHECK;
                    end else if (flag_in) begin
                        if (idx == 6'(FRAME_BITS)) begin
                            // A 60th second (leap second) cannot be framed.
                            err_out <= 1'b1;
                            state   <= SYNC;
                        end else begin
                            if (idx == 6'd0) begin
                                start_bit <= bit_in;
                            end else if (idx >= 6'(TEL_LO)) begin
                                tel[idx] <= bit_in;
                            end
                            idx <= idx + 6'd1;
                        end
                    end
                end
                CHECK: begin
                    state <= COLLECT;
                    if (frame_ok) begin
                        min_out   <= f_min;
                        hour_out  <= f_hour;
                        day_out   <= f_day;
                        wday_out  <= f_wday;
                        month_out <= f_mon;
                        year_out  <= f_year;
                        valid_out <= 1'b1;
                    end else begin
                        err_out <= 1'b1;
                    end
                    // The first second of the next minute may already be arriving.
                    if (flag_in) begin
                        start_bit <= bit_in;
                        idx       <= 6'd1;
                    end else begin
                        idx <= '0;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule
